// File: rtl/carry_tally_pkg.sv
// Shared definitions for the carry tally display: segment constants,
// the digit index type with its named positions, and a BCD increment helper.
package carry_tally_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t IDX_QIN  = 2'd0;
  localparam digit_idx_t IDX_ONES = 2'd1;
  localparam digit_idx_t IDX_TENS = 2'd2;
  localparam digit_idx_t IDX_OVF  = 2'd3;

  // Two-digit BCD increment. 99 rolls over to 00; the caller detects the wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to 7-segment decoder, active-low outputs {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  logic [6:0] lit;

  // Lit-segment pattern per hex digit, inverted for active-low drive
  always_comb begin
    lit = 7'h00;
    case (nib)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      4'hF: lit = 7'h71;
      default: lit = 7'h00;
    endcase
    seg = ~lit;
  end

endmodule

// File: rtl/carry_tally_display.sv
// Counts rising edges of an upstream carry flag into a two-digit BCD tally
// with a sticky overflow flag, and scans a 4-digit multiplexed 7-segment
// display: q_in (hex), tally ones, tally tens, overflow dash.
// Build option: define ZERO_BLANK_EN to blank the tens digit while it is 0.
// Interface: carry_in is a level; only its 0->1 transition counts. clr is a
// synchronous level that wins over a coincident carry edge.
module carry_tally_display
  import carry_tally_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] q_in,
  input  logic       carry_in,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [7:0] tally
  ,
  output logic       ovf
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic       carry_d_q, carry_d_d;
  logic [7:0] tally_q, tally_d;
  logic       ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  digit_idx_t idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;

  logic       carry_evt;
  logic [3:0] digit_nib;
  logic       force_blank;
  logic       force_dash;
  logic [6:0] dec_seg;

  seg7_decode u_dec (
    .nib (digit_nib),
    .seg (dec_seg)
  );

  // Tally update: clr first, otherwise one BCD step per carry rising edge
  always_comb begin
    carry_evt = carry_in & ~carry_d_q;
    carry_d_d = carry_in;
    tally_d   = tally_q;
    ovf_d     = ovf_q;
    if (clr) begin
      tally_d = 8'h00;
      ovf_d   = 1'b0;
    end else if (carry_evt) begin
      tally_d = bcd_inc(tally_q);
      if (tally_q == 8'h99) ovf_d = 1'b1;
    end
  end

  // Scan divider; the digit index advances on the divider's terminal count
  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = 16'd0;
      idx_d = digit_idx_t'(idx_q + 2'd1);
    end
  end

  // Select the digit content for the current index and form the next outputs
  always_comb begin
    digit_nib   = 4'h0;
    force_blank = 1'b0;
    force_dash  = 1'b0;
    case (idx_q)
      IDX_QIN:  digit_nib = q_in;
      IDX_ONES: digit_nib = tally_q[3:0];
      IDX_TENS: begin
        digit_nib = tally_q[7:4];
`ifdef ZERO_BLANK_EN
        force_blank = (tally_q[7:4] == 4'h0);
`else
        force_blank = 1'b0;
`endif
      end
      IDX_OVF: begin
        force_dash  = ovf_q;
        force_blank = ~ovf_q;
      end
      default: digit_nib = 4'h0;
    endcase
    if (force_dash)       seg_d = SEG_DASH;
    else if (force_blank) seg_d = SEG_BLANK;
    else                  seg_d = dec_seg;
    an_d = ~(4'b0001 << idx_q);
  end

  // State registers; carry_d resets high so a carry held through reset is ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_d_q <= 1'b1;
      tally_q   <= 8'h00;
      ovf_q     <= 1'b0;
      div_q     <= 16'd0;
      idx_q     <= IDX_QIN;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'hF;
    end else begin
      carry_d_q <= carry_d_d;
      tally_q   <= tally_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign tally = tally_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/carry_tally_display.md
CARRY_TALLY_DISPLAY -- requirements
Module: carry_tally_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning the number of clk cycles each display digit is held (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port q_in, input, 4 bits: count value from the upstream up/down counter.
REQ-005 SHALL have port carry_in, input, 1 bit: upstream carry/borrow flag, active high, level-type.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of the tally and the overflow flag, active high.
REQ-007 SHALL have port seg, output, 7 bits {g,f,e,d,c,b,a}: segment drive, active-low.
REQ-008 SHALL have port an, output, 4 bits: one-hot digit enable, active-low.
REQ-009 SHALL have port tally, output, 8 bits: two-digit BCD carry count {tens, ones}.
REQ-010 SHALL have port ovf, output, 1 bit: sticky flag, set on a tally wrap.

Function
REQ-011 SHALL detect a carry event as carry_in=1 while the registered previous sample carry_d=0; one event per rising edge, regardless of how long carry_in stays high.
REQ-012 SHALL update tally on the clk edge after the cycle in which the event is detected; latency from carry_in rising to tally change is 1 cycle.
REQ-013 SHALL increment tally in BCD: the ones digit goes 9 -> 0 with a carry into tens; 99 -> 00 sets ovf to 1 in the same cycle.
REQ-014 SHALL hold ovf at 1 until clr or reset; further wraps leave it at 1.
REQ-015 SHALL give clr priority over a coincident carry event; that event is discarded and tally=00, ovf=0 next cycle.
REQ-016 SHALL run a scan divider that counts 0..SCAN_DIV-1 and wraps; at terminal count the digit index advances 0->1->2->3->0.
REQ-017 SHALL map digits as follows:
- idx0 = q_in as hex 0..F
- idx1 = tally ones
- idx2 = tally tens
- idx3 = dash (segment g only) if ovf, else blank.
REQ-018 SHALL register seg and an; outputs reflect the current index and data with 1 cycle latency, and exactly one an bit is low outside reset.
REQ-019 SHALL sample q_in continuously, so a change in q_in appears on seg within 1 cycle while idx0 is active.

Reset
REQ-020 SHALL, while rst_n=0 at a clk edge, set tally=8'h00, ovf=0, divider=0, idx=0, seg=7'h7F, an=4'hF.
REQ-021 SHALL set carry_d=1 on reset, so a carry_in held high across reset release is not counted.
REQ-022 SHALL abort an in-progress scan immediately on reset mid-operation; the first clk after release drives an=4'b1110.

Configuration
REQ-023 SHALL, when ZERO_BLANK_EN is defined, blank the tens digit (seg=7'h7F, an still driven) while tally tens=0.
REQ-024 SHALL, when ZERO_BLANK_EN is undefined, always show the tens digit, including 0.

Structure
REQ-025 SHALL place the following in shared package carry_tally_pkg:
- SEG_BLANK=7'h7F, SEG_DASH=7'h3F
- the 2-bit digit index typedef
- digit index constants.
REQ-026 SHALL implement hex-to-7-segment decode (0..F, active-low) as sub-module seg7_decode, instantiated once on the muxed digit.

Verification
REQ-027 SHALL check: reset, release with carry_in=1 held -> tally=00 and an=4'b1110 on the first cycle after release.
REQ-028 SHALL check: 12 single-cycle carry_in pulses -> tally=8'h12, ovf=0.
REQ-029 SHALL check: carry_in held high for 50 cycles -> tally increments by exactly 1.
REQ-030 SHALL check: 100 pulses -> tally=8'h00, ovf=1; idx3 shows seg=SEG_DASH.
REQ-031 SHALL check: clr asserted in the same cycle as a carry edge at tally=8'h07 -> tally=00, ovf=0.
REQ-032 SHALL check: SCAN_DIV=4, q_in=4'hA, tally=8'h05 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg shows A, then 5, then 0 (blank with ZERO_BLANK_EN), then blank.
